sdp_mrdma_engine: RTL

//  Parametrised multi-destination SDP read-DMA engine: walks a surface/line/atom cube, issues

---
 rtl/sdp_mrdma_engine.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/sdp_mrdma_engine.sv
// SDP read-DMA engine: walks a surface/line/atom cube, issues credit-limited burst reads,
// buffers in-order responses in a latency FIFO and forks each atom to NUM_DST consumers.
module sdp_mrdma_engine #(
    parameter int AW        = 64,
    parameter int DW        = 512,
    parameter int LAT_DEPTH = 16,
    parameter int MAX_BURST = 8,
    parameter int NUM_DST   = 2
) (
    input  logic                         nvdla_core_clk,
    input  logic                         nvdla_core_rstn,
    input  logic                         reg_op_en,
    input  logic [AW-1:0]                reg_base_addr,
    input  logic [31:0]                  reg_line_stride,
    input  logic [31:0]                  reg_surf_stride,
    input  logic [12:0]                  reg_width,
    input  logic [12:0]                  reg_height,
    input  logic [12:0]                  reg_surfaces,
    input  logic [NUM_DST-1:0]           reg_dst_mask,
    input  logic                         reg_perf_en,
    output logic                         req_valid,
    input  logic                         req_ready,
    output logic [AW-1:0]                req_addr,
    output logic [$clog2(MAX_BURST)-1:0] req_len,
    input  logic                         rsp_valid,
    output logic                         rsp_ready,
    input  logic [DW-1:0]                rsp_data,
    output logic                         cdt_pop,
    output logic [NUM_DST-1:0]           dst_valid,
    input  logic [NUM_DST-1:0]           dst_ready,
    output logic [DW-1:0]                dst_data,
    output logic                         done,
    output logic [31:0]                  stall_cnt
);

    // state   | meaning
    // S_IDLE  | waiting for reg_op_en; reg_* sampled on op_load
    // S_RUN   | issuing read requests for the cube
    // S_DRAIN | all requests accepted, waiting for the last atom to pop
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    localparam int LW = $clog2(MAX_BURST);
    localparam int PW = $clog2(LAT_DEPTH);
    localparam int CW = $clog2(LAT_DEPTH + 1);

    state_t              state_q, state_d;
    logic [AW-1:0]       base_q, base_d, line_addr_q, line_addr_d;
    logic [AW-1:0]       surf_addr_q, surf_addr_d, chunk_addr_q, chunk_addr_d;
    logic [31:0]         lstr_q, lstr_d, sstr_q, sstr_d, stall_q, stall_d;
    logic [12:0]         width_q, width_d, height_q, height_d, surfs_q, surfs_d;
    logic [12:0]         chunk_q, chunk_d, line_q, line_d, surf_q, surf_d;
    logic [NUM_DST-1:0]  mask_q, mask_d, taken_q, taken_d;
    logic                perf_q, perf_d;
    logic [CW-1:0]       credit_q, credit_d;
    logic [39:0]         left_q, left_d;
    logic [PW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DW-1:0]       mem_q [LAT_DEPTH];

    logic                op_load, last_chunk, last_line, last_surf, req_acc;
    logic                fifo_empty, fifo_full, fifo_wr;
    logic [CW-1:0]       need;
    logic [NUM_DST-1:0]  dst_hs;
    logic [39:0]         total;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        line_addr_d  = line_addr_q;
        surf_addr_d  = surf_addr_q;
        chunk_addr_d = chunk_addr_q;
        lstr_d       = lstr_q;
        sstr_d       = sstr_q;
        stall_d      = stall_q;
        width_d      = width_q;
        height_d     = height_q;
        surfs_d      = surfs_q;
        chunk_d      = chunk_q;
        line_d       = line_q;
        surf_d       = surf_q;
        mask_d       = mask_q;
        perf_d       = perf_q;

        op_load    = reg_op_en && (state_q == S_IDLE);
        last_chunk = (chunk_q == (width_q >> LW));
        last_line  = (line_q == height_q);
        last_surf  = (surf_q == surfs_q);
        req_len    = last_chunk ? width_q[LW-1:0] : LW'(MAX_BURST - 1);
        need       = CW'(req_len) + CW'(1);
        req_valid  = (state_q == S_RUN) && (credit_q >= need);
        req_addr   = chunk_addr_q;
        req_acc    = req_valid && req_ready;

        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        rsp_ready  = !fifo_full;
        fifo_wr    = rsp_valid && rsp_ready;
        dst_data   = mem_q[rd_ptr_q[PW-1:0]];

        // An atom pops once every masked consumer has either taken it earlier or takes it now.
        dst_valid  = fifo_empty ? '0 : (mask_q & ~taken_q);
        dst_hs     = dst_valid & dst_ready;
        cdt_pop    = !fifo_empty && (&(~mask_q | taken_q | dst_hs));
        taken_d    = cdt_pop ? '0 : (taken_q | dst_hs);
        done       = cdt_pop && (state_q == S_DRAIN) && (left_q == 40'd1);
        stall_cnt  = stall_q;

        wr_ptr_d = fifo_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = cdt_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        credit_d = credit_q - (req_acc ? need : CW'(0)) + (cdt_pop ? CW'(1) : CW'(0));
        left_d   = cdt_pop ? left_q - 40'd1 : left_q;
        total    = 40'({1'b0, reg_width} + 14'd1) * 40'({1'b0, reg_height} + 14'd1)
                 * 40'({1'b0, reg_surfaces} + 14'd1);

        if (perf_q && req_valid && !req_ready && (stall_q != 32'hFFFF_FFFF))
            stall_d = stall_q + 32'd1;

        if (op_load) begin
            state_d      = S_RUN;
            base_d       = reg_base_addr;
            line_addr_d  = reg_base_addr;
            surf_addr_d  = reg_base_addr;
            chunk_addr_d = reg_base_addr;
            lstr_d       = reg_line_stride;
            sstr_d       = reg_surf_stride;
            width_d      = reg_width;
            height_d     = reg_height;
            surfs_d      = reg_surfaces;
            mask_d       = reg_dst_mask;
            perf_d       = reg_perf_en;
            chunk_d      = '0;
            line_d       = '0;
            surf_d       = '0;
            left_d       = total;
            stall_d      = '0;
        end else if (req_acc) begin
            if (!last_chunk) begin
                chunk_d      = chunk_q + 13'd1;
                chunk_addr_d = chunk_addr_q + AW'(MAX_BURST);
            end else begin
                chunk_d = '0;
                if (!last_line) begin
                    line_d       = line_q + 13'd1;
                    line_addr_d  = line_addr_q + AW'(lstr_q);
                    chunk_addr_d = line_addr_q + AW'(lstr_q);
                end else begin
                    line_d = '0;
                    if (!last_surf) begin
                        surf_d       = surf_q + 13'd1;
                        surf_addr_d  = surf_addr_q + AW'(sstr_q);
                        line_addr_d  = surf_addr_q + AW'(sstr_q);
                        chunk_addr_d = surf_addr_q + AW'(sstr_q);
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
        end else if (done) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            line_addr_q  <= '0;
            surf_addr_q  <= '0;
            chunk_addr_q <= '0;
            lstr_q       <= '0;
            sstr_q       <= '0;
            stall_q      <= '0;
            width_q      <= '0;
            height_q     <= '0;
            surfs_q      <= '0;
            chunk_q      <= '0;
            line_q       <= '0;
            surf_q       <= '0;
            mask_q       <= '0;
            taken_q      <= '0;
            perf_q       <= 1'b0;
            credit_q     <= CW'(LAT_DEPTH);
            left_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            line_addr_q  <= line_addr_d;
            surf_addr_q  <= surf_addr_d;
            chunk_addr_q <= chunk_addr_d;
            lstr_q       <= lstr_d;
            sstr_q       <= sstr_d;
            stall_q      <= stall_d;
            width_q      <= width_d;
            height_q     <= height_d;
            surfs_q      <= surfs_d;
            chunk_q      <= chunk_d;
            line_q       <= line_d;
            surf_q       <= surf_d;
            mask_q       <= mask_d;
            taken_q      <= taken_d;
            perf_q       <= perf_d;
            credit_q     <= credit_d;
            left_q       <= left_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // Data array needs no reset; the pointers define validity.
    always_ff @(posedge nvdla_core_clk) begin
        if (fifo_wr)
            mem_q[wr_ptr_q[PW-1:0]] <= rsp_data;
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rstn) begin
            assert (!rsp_valid || rsp_ready);
            assert (credit_q <= CW'(LAT_DEPTH));
        end
    end

endmodule
